// File: rtl/makina_pkg.sv
// Shared types and default widths for the 16-bit core front end.
package makina_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 16;

  typedef enum logic [1:0] {
    F_IDLE  = 2'd0,
    F_FETCH = 2'd1,
    F_FLUSH = 2'd2,
    F_HALT  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_buffer.sv
// One-entry valid/ready holding register between instruction memory and decode.
// Flush wins over load, load wins over consume so a same-cycle consume+load
// replaces the entry without a bubble.
module fetch_buffer #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load_i,
  input  logic               consume_i,
  input  logic               flush_i,
  input  logic [INSTR_W-1:0] data_i,
  input  logic [ADDR_W-1:0]  pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] data_o,
  output logic [ADDR_W-1:0]  pc_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] data_q;
  logic [ADDR_W-1:0]  pc_q;

  // Entry register: flush drops the word, load captures a new one, consume empties it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      pc_q    <= pc_i;
    end else if (consume_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the fetch address, runs the imem req/ack
// handshake, and feeds decode through a one-entry buffer.
//
//   state   | meaning
//   F_IDLE  | one settling cycle after reset
//   F_FETCH | requesting whenever the buffer has room
//   F_FLUSH | waiting out a stale request after a branch; its data is dropped
//   F_HALT  | no requests; buffer still drains to decode
module fetch_controller #(
  parameter int                ADDR_W       = makina_pkg::ADDR_W,
  parameter int                INSTR_W      = makina_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               halt,
  output logic               halted
);

  import makina_pkg::*;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              halted_q;
  logic              room, ack, load, consume;

  // Request is decoded from registered state plus the room check only, so
  // instr_ready is the sole combinational input-to-output path.
  assign room     = !instr_valid || instr_ready;
  assign imem_req = (state_q == F_FLUSH) || ((state_q == F_FETCH) && room);
  assign ack      = imem_ack && imem_req;
  assign load     = (state_q == F_FETCH) && ack && !branch_taken;
  assign consume  = instr_valid && instr_ready;

  // Next fetch address: branch overrides the post-ack increment (wraps mod 2^ADDR_W).
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (branch_taken)  fetch_pc_d = branch_target;
    else if (load)     fetch_pc_d = fetch_pc_q + ADDR_W'(1);
  end

  // Next state with priority branch > ack > halt.
  always_comb begin
    state_d = state_q;
    case (state_q)
      F_IDLE:  state_d = halt ? F_HALT : F_FETCH;
      F_FETCH: begin
        if (branch_taken)         state_d = (imem_req && !ack) ? F_FLUSH : F_FETCH;
        else if (ack)             state_d = halt ? F_HALT : F_FETCH;
        else if (halt && !imem_req) state_d = F_HALT;
      end
      F_FLUSH: if (ack)  state_d = halt ? F_HALT : F_FETCH;
      F_HALT:  if (!halt) state_d = F_FETCH;
      default: state_d = F_IDLE;
    endcase
  end

  // The stale address must stay on the bus for the whole flush.
  assign addr_d = (state_d == F_FLUSH) ? addr_q : fetch_pc_d;

  // State, fetch pointer, bus address and halted flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= F_IDLE;
      fetch_pc_q <= RESET_VECTOR;
      addr_q     <= RESET_VECTOR;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      halted_q   <= (state_d == F_HALT);
    end
  end

  assign imem_addr = addr_q;
  assign halted    = halted_q;

  fetch_buffer #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .load_i    (load),
    .consume_i (consume),
    .flush_i   (branch_taken),
    .data_i    (imem_rdata),
    .pc_i      (fetch_pc_q),
    .valid_o   (instr_valid),
    .data_o    (instr_data),
    .pc_o      (instr_pc)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a small wait-state memory model.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [15:0] instr_pc;
  logic        instr_ready = 1'b1;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = '0;
  logic        halt = 1'b0;
  logic        halted;

  int tests = 0;
  int fails = 0;
  int mem_wait = 0;
  int mem_ctr;

  localparam logic [15:0] KEY = 16'hA5A5;

  fetch_controller dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // Memory: acks after mem_wait request cycles; data is the address scrambled.
  assign imem_ack   = imem_req && (mem_ctr >= mem_wait);
  assign imem_rdata = imem_addr ^ KEY;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  mem_ctr <= 0;
    else if (imem_req && !imem_ack) mem_ctr <= mem_ctr + 1;
    else                           mem_ctr <= 0;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int wait_n, input logic rdy);
    @(negedge clk);
    reset_n = 1'b0;
    branch_taken = 1'b0;
    halt = 1'b0;
    instr_ready = rdy;
    mem_wait = wait_n;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL reset_req got %0b want 0", imem_req); end
    tests++; if (imem_addr !== 16'h0000) begin fails++; $display("FAIL reset_addr got %h want 0000", imem_addr); end
    tests++; if (instr_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", instr_valid); end
    tests++; if (instr_data !== 16'h0000 || instr_pc !== 16'h0000) begin fails++; $display("FAIL reset_buf got data %h pc %h want 0000 0000", instr_data, instr_pc); end
    tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted got %0b want 0", halted); end
  endtask

  task automatic test_zero_wait();
    logic [15:0] exp;
    do_reset(0, 1'b1);
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL idle_req got %0b want 0", imem_req); end
    tick();
    tests++; if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin fails++; $display("FAIL first_req got req %0b addr %h want 1 0000", imem_req, imem_addr); end
    tick();
    for (int i = 0; i < 3; i++) begin
      exp = 16'(i);
      tests++; if ({instr_valid, instr_pc} !== {1'b1, exp}) begin fails++; $display("FAIL zw_pc%0d got v %0b pc %h want 1 %h", i, instr_valid, instr_pc, exp); end
      tests++; if (instr_data !== (exp ^ KEY)) begin fails++; $display("FAIL zw_data%0d got %h want %h", i, instr_data, exp ^ KEY); end
      tick();
    end
  endtask

  task automatic test_wait_states();
    logic [15:0] exp;
    do_reset(3, 1'b1);
    tick();
    for (int w = 0; w < 2; w++) begin
      exp = 16'(w);
      for (int i = 0; i < 4; i++) begin
        tests++; if ({imem_req, imem_addr} !== {1'b1, exp}) begin fails++; $display("FAIL ws_hold%0d_%0d got req %0b addr %h want 1 %h", w, i, imem_req, imem_addr, exp); end
        tick();
      end
      tests++; if ({instr_valid, instr_pc} !== {1'b1, exp}) begin fails++; $display("FAIL ws_word%0d got v %0b pc %h want 1 %h", w, instr_valid, instr_pc, exp); end
      tests++; if (imem_addr !== exp + 16'h1) begin fails++; $display("FAIL ws_advance%0d got %h want %h", w, imem_addr, exp + 16'h1); end
    end
  endtask

  task automatic test_backpressure();
    do_reset(0, 1'b0);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      tests++; if ({imem_req, instr_valid, instr_pc} !== {1'b0, 1'b1, 16'h0000}) begin fails++; $display("FAIL bp_stall%0d got req %0b v %0b pc %h want 0 1 0000", i, imem_req, instr_valid, instr_pc); end
      tick();
    end
    instr_ready = 1'b1;
    #1;
    tests++; if ({imem_req, imem_addr} !== {1'b1, 16'h0001}) begin fails++; $display("FAIL bp_resume got req %0b addr %h want 1 0001", imem_req, imem_addr); end
    tick();
    tests++; if ({instr_valid, instr_pc} !== {1'b1, 16'h0001}) begin fails++; $display("FAIL bp_pc1 got v %0b pc %h want 1 0001", instr_valid, instr_pc); end
    tick();
    tests++; if ({instr_valid, instr_pc} !== {1'b1, 16'h0002}) begin fails++; $display("FAIL bp_pc2 got v %0b pc %h want 1 0002", instr_valid, instr_pc); end
  endtask

  task automatic test_branch_wait();
    bit ok;
    do_reset(2, 1'b1);
    tick();
    branch_taken = 1'b1;
    branch_target = 16'h0100;
    tick();
    branch_taken = 1'b0;
    tests++; if ({imem_req, imem_addr, instr_valid} !== {1'b1, 16'h0000, 1'b0}) begin fails++; $display("FAIL br_flush got req %0b addr %h v %0b want 1 0000 0", imem_req, imem_addr, instr_valid); end
    tick();
    tick();
    tests++; if ({imem_addr, instr_valid} !== {16'h0100, 1'b0}) begin fails++; $display("FAIL br_discard got addr %h v %0b want 0100 0", imem_addr, instr_valid); end
    wait_valid(ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL br_timeout got no word want word"); end
    tests++; if ({instr_pc, instr_data} !== {16'h0100, 16'h0100 ^ KEY}) begin fails++; $display("FAIL br_word got pc %h data %h want 0100 %h", instr_pc, instr_data, 16'h0100 ^ KEY); end
  endtask

  task automatic test_branch_on_ack();
    bit ok;
    do_reset(2, 1'b1);
    tick();
    tick();
    tick();
    branch_taken = 1'b1;
    branch_target = 16'h0100;
    tick();
    branch_taken = 1'b0;
    tests++; if ({imem_req, imem_addr, instr_valid} !== {1'b1, 16'h0100, 1'b0}) begin fails++; $display("FAIL brack_redirect got req %0b addr %h v %0b want 1 0100 0", imem_req, imem_addr, instr_valid); end
    wait_valid(ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL brack_timeout got no word want word"); end
    tests++; if (instr_pc !== 16'h0100) begin fails++; $display("FAIL brack_word got pc %h want 0100", instr_pc); end
  endtask

  task automatic test_wrap();
    logic [15:0] wexp [3];
    wexp = '{16'hFFFE, 16'hFFFF, 16'h0000};
    do_reset(0, 1'b1);
    tick();
    branch_taken = 1'b1;
    branch_target = 16'hFFFE;
    tick();
    branch_taken = 1'b0;
    tests++; if ({imem_addr, instr_valid} !== {16'hFFFE, 1'b0}) begin fails++; $display("FAIL wrap_redirect got addr %h v %0b want fffe 0", imem_addr, instr_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if ({instr_valid, instr_pc} !== {1'b1, wexp[i]}) begin fails++; $display("FAIL wrap_pc%0d got v %0b pc %h want 1 %h", i, instr_valid, instr_pc, wexp[i]); end
    end
  endtask

  task automatic test_halt_and_reset();
    bit ok;
    do_reset(2, 1'b1);
    tick();
    halt = 1'b1;
    tick();
    tests++; if ({imem_req, halted} !== {1'b1, 1'b0}) begin fails++; $display("FAIL halt_pending got req %0b halted %0b want 1 0", imem_req, halted); end
    tick();
    tick();
    tests++; if ({instr_valid, instr_pc, halted, imem_req} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin fails++; $display("FAIL halt_enter got v %0b pc %h halted %0b req %0b want 1 0000 1 0", instr_valid, instr_pc, halted, imem_req); end
    tick();
    tests++; if ({instr_valid, halted, imem_req} !== {1'b0, 1'b1, 1'b0}) begin fails++; $display("FAIL halt_drain got v %0b halted %0b req %0b want 0 1 0", instr_valid, halted, imem_req); end
    halt = 1'b0;
    tick();
    tests++; if ({halted, imem_req, imem_addr} !== {1'b0, 1'b1, 16'h0001}) begin fails++; $display("FAIL halt_release got halted %0b req %0b addr %h want 0 1 0001", halted, imem_req, imem_addr); end
    wait_valid(ok);
    tests++; if ({ok, instr_pc} !== {1'b1, 16'h0001}) begin fails++; $display("FAIL halt_resume got ok %0b pc %h want 1 0001", ok, instr_pc); end
    tests++; if (imem_req !== 1'b1) begin fails++; $display("FAIL rst_pre got req %0b want 1", imem_req); end
    #2;
    reset_n = 1'b0;
    #1;
    tests++; if ({imem_req, imem_addr, halted} !== {1'b0, 16'h0000, 1'b0}) begin fails++; $display("FAIL rst_mid_bus got req %0b addr %h halted %0b want 0 0000 0", imem_req, imem_addr, halted); end
    tests++; if ({instr_valid, instr_data, instr_pc} !== {1'b0, 16'h0000, 16'h0000}) begin fails++; $display("FAIL rst_mid_buf got v %0b data %h pc %h want 0 0000 0000", instr_valid, instr_data, instr_pc); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_backpressure();
    test_branch_wait();
    test_branch_on_ack();
    test_wrap();
    test_halt_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
